ex_mem_latch: RTL

- EX→MEM pipeline boundary. Captures one ALU result per accepted transfer: aluOut, zero, exceptionCode, plus the decode side-band fields.
- Resolves branches: taken when opcode is OPCODE_BRANCH and zero is 1.
- Presents results to the memory stage through a valid/ready handshake.
- Contains a 2-entry skid buffer, so in_ready is registered and back-pressure never forms a combinational path to the ALU.

---
 rtl/ex_mem_latch.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ex_mem_latch.sv
// EX->MEM pipeline latch with a 2-entry skid buffer and a registered in_ready.
// Optional performance counters are enabled with EX_MEM_PERF_COUNT_EN.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module ex_mem_latch #(
    parameter int unsigned WORD_SIZE  = `WORD_SIZE,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            in_opcode,
    input  logic [WORD_SIZE-1:0]  in_alu_out,
    input  logic                  in_zero,
    input  logic [WORD_SIZE-1:0]  in_exc,
    input  logic [WORD_SIZE-1:0]  in_store_data,
    input  logic [REG_ADDR_W-1:0] in_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [6:0]            out_opcode,
    output logic [WORD_SIZE-1:0]  out_alu_out,
    output logic [WORD_SIZE-1:0]  out_store_data,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [WORD_SIZE-1:0]  out_exc,
    output logic                  out_exc_valid,
    output logic                  out_branch_taken,
    output logic                  out_is_mem
`ifdef EX_MEM_PERF_COUNT_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_branch_taken
`endif
);

    localparam logic [6:0] OpcodeLoad   = 7'b0000011;
    localparam logic [6:0] OpcodeStore  = 7'b0100011;
    localparam logic [6:0] OpcodeBranch = 7'b1100011;

    typedef struct packed {
        logic [6:0]            opcode;
        logic [WORD_SIZE-1:0]  alu_out;
        logic [WORD_SIZE-1:0]  exc;
        logic [WORD_SIZE-1:0]  store_data;
        logic [REG_ADDR_W-1:0] rd;
        logic                  taken;
    } entry_t;

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e state_q, state_d;
    entry_t main_q, main_d, skid_q, skid_d, in_entry;
    logic   in_ready_q, in_ready_d;
    logic   accept, drain;

    assign accept = in_valid && in_ready_q;
    assign drain  = out_valid && out_ready;

    // Branch decision is frozen at capture time.
    assign in_entry = '{
        opcode:     in_opcode,
        alu_out:    in_alu_out,
        exc:        in_exc,
        store_data: in_store_data,
        rd:         in_rd,
        taken:      (in_opcode == OpcodeBranch) && in_zero
    };

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        main_d  = in_entry;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (accept && drain) begin
                        main_d = in_entry;
                    end else if (accept) begin
                        skid_d  = in_entry;
                        state_d = StFull;
                    end else if (drain) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
        in_ready_d = (state_d != StFull);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StEmpty;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready         = in_ready_q;
    assign out_valid        = (state_q != StEmpty);
    assign out_opcode       = main_q.opcode;
    assign out_alu_out      = main_q.alu_out;
    assign out_store_data   = main_q.store_data;
    assign out_rd           = main_q.rd;
    assign out_exc          = main_q.exc;
    assign out_exc_valid    = out_valid && (main_q.exc != '0);
    assign out_branch_taken = out_valid && main_q.taken;
    assign out_is_mem       = out_valid &&
                              ((main_q.opcode == OpcodeLoad) || (main_q.opcode == OpcodeStore));

`ifdef EX_MEM_PERF_COUNT_EN
    logic [31:0] stall_cnt_q, branch_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            branch_cnt_q <= '0;
        end else begin
            if (out_valid && !out_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (accept && !flush && in_entry.taken) branch_cnt_q <= branch_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cycles = stall_cnt_q;
    assign perf_branch_taken = branch_cnt_q;
`endif

endmodule
